// File: rtl/posit_sched_pkg.sv
// Shared types and helpers for the posit adder scheduler.
// Tag stages are sized for the largest supported requester count (8).
package posit_sched_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic int tagw(input int nreq);
    return (clog2(nreq) < 1) ? 1 : clog2(nreq);
  endfunction

  localparam int NREQ_MAX = 8;
  localparam int TAGW     = tagw(NREQ_MAX);

  typedef struct packed {
    logic            v;
    logic [TAGW-1:0] tag;
  } tag_stage_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching from the pointer.
// The pointer moves past the winner whenever advance is asserted.
module rr_arbiter
  import posit_sched_pkg::*;
#(
  parameter  int NREQ = 2,
  localparam int IDXW = tagw(NREQ)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic [NREQ-1:0] grant,
  output logic [IDXW-1:0] winner
);

  logic [IDXW-1:0] ptr;
  int unsigned     idx;
  logic            found;

  always_comb begin
    grant  = '0;
    winner = '0;
    idx    = 0;
    found  = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(ptr) + k) % NREQ;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        winner     = IDXW'(idx);
        found      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (winner == IDXW'(NREQ - 1)) ? '0 : winner + 1'b1;
    end
  end

endmodule

// File: rtl/posit_add_sched.sv
// Shares one fixed-latency posit adder core between NREQ requesters:
// round-robin issue, tag pipeline tracking, per-requester result registers.
module posit_add_sched
  import posit_sched_pkg::*;
#(
  parameter int N    = 8,
  parameter int es   = 4,
  parameter int NREQ = 2,
  parameter int LAT  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  output logic              core_in_valid,
  output logic [N-1:0]      core_a,
  output logic [N-1:0]      core_b,
  input  logic [N-1:0]      core_r,
  output logic [NREQ-1:0]   res_valid,
  input  logic [NREQ-1:0]   res_ready,
  output logic [NREQ*N-1:0] res_data
);

  localparam int IDXW = tagw(NREQ);

  if (es < 0 || es >= N) begin : g_es_range
    $error("posit_add_sched: es must lie in 0..N-1");
  end

  logic [NREQ-1:0] busy;
  logic [NREQ-1:0] eligible;
  logic [NREQ-1:0] grant;
  logic [IDXW-1:0] winner;
  tag_stage_t      pipe [LAT+1];

  // Reset masks eligibility so req_ready reads 0 while reset is held.
  assign eligible  = req_valid & ~busy & {NREQ{~reset}};
  assign req_ready = grant;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (eligible),
    .advance (|grant),
    .grant   (grant),
    .winner  (winner)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      core_in_valid <= 1'b0;
      core_a        <= '0;
      core_b        <= '0;
      res_valid     <= '0;
      res_data      <= '0;
      busy          <= '0;
      for (int unsigned s = 0; s <= LAT; s++) pipe[s] <= '0;
    end else begin
      core_in_valid <= |grant;
      if (|grant) begin
        core_a <= req_a[winner*N +: N];
        core_b <= req_b[winner*N +: N];
      end
      pipe[0] <= '{v: |grant, tag: TAGW'(winner)};
      for (int unsigned s = 1; s <= LAT; s++) pipe[s] <= pipe[s-1];
      // Busy covers issue through consumption, so capture and consume never hit one slot together.
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (grant[i]) begin
          busy[i] <= 1'b1;
        end else if (res_valid[i] && res_ready[i]) begin
          busy[i] <= 1'b0;
        end
        if (res_valid[i] && res_ready[i]) res_valid[i] <= 1'b0;
        if (pipe[LAT].v && pipe[LAT].tag == TAGW'(i)) begin
          res_valid[i]       <= 1'b1;
          res_data[i*N +: N] <= core_r;
        end
      end
    end
  end

endmodule

// File: tb/tb_posit_add_sched.sv
// Directed bench for posit_add_sched with an XOR stand-in core and a
// queue-based reference model checked on every falling edge.
module tb_posit_add_sched;
  localparam int N    = 8;
  localparam int NREQ = 2;
  localparam int LAT  = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_valid, req_ready, res_valid, res_ready;
  logic [NREQ*N-1:0] req_a, req_b, res_data;
  logic              core_in_valid;
  logic [N-1:0]      core_a, core_b, core_r;
  logic [N-1:0]      cpipe [LAT];

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  posit_add_sched #(.N(N), .es(4), .NREQ(NREQ), .LAT(LAT)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_a         (req_a),
    .req_b         (req_b),
    .core_in_valid (core_in_valid),
    .core_a        (core_a),
    .core_b        (core_b),
    .core_r        (core_r),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_data      (res_data)
  );

  // Stand-in core: result is a ^ b, visible LAT cycles after the operands.
  always @(posedge clk) begin
    cpipe[0] <= core_a ^ core_b;
    for (int i = 1; i < LAT; i++) cpipe[i] <= cpipe[i-1];
  end
  assign core_r = cpipe[LAT-1];

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: state as seen during the current cycle.
  typedef struct {
    int           slot;
    logic [N-1:0] val;
    int           due;
  } op_t;

  int           mptr  = 0;
  bit [NREQ-1:0] mbusy = '0;
  bit [NREQ-1:0] mresv = '0;
  logic [N-1:0] mresd [NREQ];
  bit           mciv  = 1'b0;
  logic [N-1:0] mca   = '0;
  logic [N-1:0] mcb   = '0;
  op_t          inflight [$];

  always @(negedge clk) begin : model
    int           w;
    int           idx;
    logic [NREQ-1:0] eg;
    w  = -1;
    eg = '0;
    if (!reset) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (mptr + k) % NREQ;
        if (w < 0 && req_valid[idx] && !mbusy[idx]) w = idx;
      end
    end
    if (w >= 0) eg[w] = 1'b1;

    check("req_ready", req_ready, eg);
    check("core_in_valid", core_in_valid, mciv);
    if (mciv) begin
      check("core_a", core_a, mca);
      check("core_b", core_b, mcb);
    end
    check("res_valid", res_valid, mresv);
    for (int i = 0; i < NREQ; i++)
      if (mresv[i]) check("res_data", res_data[i*N +: N], mresd[i]);

    if (reset) begin
      mptr  = 0;
      mbusy = '0;
      mresv = '0;
      mciv  = 1'b0;
      mca   = '0;
      mcb   = '0;
      inflight.delete();
    end else begin
      for (int i = 0; i < NREQ; i++)
        if (mresv[i] && res_ready[i]) begin
          mresv[i] = 1'b0;
          mbusy[i] = 1'b0;
        end
      mciv = (w >= 0);
      if (w >= 0) begin
        mca      = req_a[w*N +: N];
        mcb      = req_b[w*N +: N];
        mbusy[w] = 1'b1;
        mptr     = (w + 1) % NREQ;
        inflight.push_back('{slot: w, val: mca ^ mcb, due: cyc + LAT + 2});
      end
      for (int q = inflight.size() - 1; q >= 0; q--)
        if (inflight[q].due == cyc + 1) begin
          mresv[inflight[q].slot] = 1'b1;
          mresd[inflight[q].slot] = inflight[q].val;
          inflight.delete(q);
        end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  int g0, g1;

  initial begin
    reset = 1'b1; req_valid = '0; res_ready = '0; req_a = '0; req_b = '0;
    step(3);
    check("reset_res_valid", res_valid, 0);
    check("reset_res_data", res_data, 0);
    check("reset_core_in_valid", core_in_valid, 0);
    reset = 1'b0;
    step();

    // 1: single op, result held while res_ready low
    req_valid = 2'b01; req_a[7:0] = 8'h40; req_b[7:0] = 8'h12;
    #1 check("t1_ready", req_ready, 2'b01);
    step(); req_valid = '0;
    check("t1_civ", core_in_valid, 1);
    check("t1_core_a", core_a, 8'h40);
    step(3);
    check("t1_not_yet", res_valid, 2'b00);
    step();
    check("t1_valid", res_valid, 2'b01);
    check("t1_data", res_data[7:0], 8'h52);
    repeat (4) begin
      step();
      check("t1_hold_valid", res_valid, 2'b01);
      check("t1_hold_data", res_data[7:0], 8'h52);
    end
    res_ready = 2'b01;
    step(); res_ready = '0;
    check("t1_consumed", res_valid, 2'b00);

    // 4: back-to-back issue from different requesters
    res_ready = 2'b11;
    req_valid = 2'b01; req_a[7:0] = 8'h10; req_b[7:0] = 8'h01;
    step();
    req_valid = 2'b10; req_a[15:8] = 8'h20; req_b[15:8] = 8'h02;
    step(); req_valid = '0;
    step(3);
    check("t4_valid0", res_valid, 2'b01);
    check("t4_data0", res_data[7:0], 8'h11);
    step();
    check("t4_valid1", res_valid, 2'b10);
    check("t4_data1", res_data[15:8], 8'h22);
    step(2);

    // 2: contention, both requesters always valid
    req_valid = 2'b11; req_a = 16'h0201; req_b = '0;
    g0 = 0; g1 = 0;
    repeat (24) begin
      #1;
      if (req_ready[0]) g0++;
      if (req_ready[1]) g1++;
      step();
    end
    req_valid = '0;
    check("t2_grants0", g0, 4);
    check("t2_grants1", g1, 4);
    step(8);

    // 3: busy blocks re-issue until the result is consumed
    res_ready = '0;
    req_valid = 2'b01; req_a[7:0] = 8'h5A; req_b[7:0] = 8'h0F;
    #1 check("t3_first", req_ready, 2'b01);
    repeat (9) begin
      step();
      #1 check("t3_blocked", req_ready, 2'b00);
    end
    step(); res_ready = 2'b01;
    #1 check("t3_consume_cycle", req_ready, 2'b00);
    step(); res_ready = '0;
    #1 check("t3_regrant", req_ready, 2'b01);
    step(); req_valid = '0; res_ready = 2'b11;
    step(8);

    // 6: consume and request on slot 1 in the same cycle
    res_ready = '0;
    req_valid = 2'b10; req_a[15:8] = 8'h33; req_b[15:8] = 8'h0F;
    #1 check("t6_first", req_ready, 2'b10);
    step(); req_valid = '0;
    step(6);
    check("t6_pending", res_valid, 2'b10);
    check("t6_data", res_data[15:8], 8'h3C);
    res_ready = 2'b10; req_valid = 2'b10;
    #1 check("t6_same_cycle", req_ready, 2'b00);
    step(); res_ready = '0;
    #1 check("t6_next_cycle", req_ready, 2'b10);
    step(); req_valid = '0;
    step(3);
    check("t6_not_yet", res_valid, 2'b00);
    step();
    check("t6_result", res_valid, 2'b10);
    res_ready = 2'b11;
    step(2);

    // 5: reset with an operation in flight
    res_ready = '0;
    req_valid = 2'b01; req_a[7:0] = 8'h55; req_b[7:0] = 8'hAA;
    step(); req_valid = '0;
    step(); reset = 1'b1;
    step(); reset = 1'b0;
    repeat (7) begin
      check("t5_discarded", res_valid, 2'b00);
      step();
    end
    req_valid = 2'b11; req_a = 16'h010F; req_b = 16'h80F0;
    #1 check("t5_ptr_reset", req_ready, 2'b01);
    step();
    #1 check("t5_second", req_ready, 2'b10);
    step(); req_valid = '0;
    step(3);
    check("t5_valid0", res_valid, 2'b01);
    check("t5_data0", res_data[7:0], 8'hFF);
    step();
    check("t5_valid1", res_valid, 2'b11);
    check("t5_data1", res_data[15:8], 8'h81);
    res_ready = 2'b11;
    step(3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
